// File: rtl/sysid_check_ctrl_pkg.sv
// Shared types and constants for the system-ID check controller.
package sysid_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_ID_REQ,
        ST_RD_ID_WAIT,
        ST_RD_TS_REQ,
        ST_RD_TS_WAIT,
        ST_CHECK,
        ST_DONE
    } state_t;

    localparam logic SYSID_ADDR_ID = 1'b0;
    localparam logic SYSID_ADDR_TS = 1'b1;

    localparam logic [31:0] DEFAULT_EXPECTED_ID = 32'd2;
    localparam logic [31:0] DEFAULT_EXPECTED_TS = 32'd1547124852;

    // Counter width able to hold 0..n, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n == 0) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/sysid_check_ctrl_if.sv
// Avalon-MM read-only link between the check controller and the sysid slave.
interface sysid_check_ctrl_if;

    logic        address;
    logic        read;
    logic        waitrequest;
    logic [31:0] readdata;
    logic        readdatavalid;

    modport master (
        output address,
        output read,
        input  waitrequest,
        input  readdata,
        input  readdatavalid
    );

    modport slave (
        input  address,
        input  read,
        output waitrequest,
        output readdata,
        output readdatavalid
    );

endinterface

// File: rtl/sysid_check_ctrl_avm_read_txn.sv
// One Avalon read transaction: strobe generation, completion detection and
// per-transaction timeout counting.
module avm_read_txn
    import sysid_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                      clock,
    input  logic                      reset_n,
    input  logic                      req_phase,
    input  logic                      wait_phase,
    input  logic                      address,
    sysid_check_ctrl_if.master        avm,
    output logic                      accept,
    output logic                      complete,
    output logic                      expired,
    output logic [31:0]               data
);

    localparam int unsigned CNT_W = cnt_width(TIMEOUT_CYCLES);

    logic [CNT_W-1:0] cnt;
    logic             active;
    logic             last_cycle;

    assign avm.read    = req_phase;
    assign avm.address = address;

    assign active     = req_phase | wait_phase;
    assign accept     = req_phase & ~avm.waitrequest;
    // A zero-latency slave completes in the accept cycle itself.
    assign complete   = (accept | wait_phase) & avm.readdatavalid;
    assign last_cycle = (cnt == CNT_W'(TIMEOUT_CYCLES - 1));
    assign expired    = active & last_cycle & ~complete;
    assign data       = avm.readdata;

    // Zero outside REQ/WAIT and after each completion, so every REQ entry
    // starts counting from zero.
    always_ff @(posedge clock) begin
        if (!reset_n || !active || complete || expired) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/sysid_check_ctrl.sv
// Boot-time system-ID checker: reads ID and timestamp words over Avalon-MM,
// compares them to expected values and publishes pass/fail status.
module sysid_check_ctrl
    import sysid_pkg::*;
#(
    parameter logic [31:0] EXPECTED_ID    = DEFAULT_EXPECTED_ID,
    parameter logic [31:0] EXPECTED_TS    = DEFAULT_EXPECTED_TS,
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned MAX_RETRIES    = 3,
    parameter bit          AUTO_START     = 1'b1
) (
    input  logic                                 clock,
    input  logic                                 reset_n,
    input  logic                                 start,
    sysid_check_ctrl_if.master                   avm,
    output logic                                 busy,
    output logic                                 done,
    output logic                                 pass,
    output logic                                 id_match,
    output logic                                 ts_match,
    output logic                                 timeout,
    output logic [cnt_width(MAX_RETRIES)-1:0]    retry_cnt,
    output logic [31:0]                          id_value,
    output logic [31:0]                          ts_value
);

    localparam int unsigned RETRY_W = cnt_width(MAX_RETRIES);

    state_t      state;
    state_t      state_nxt;
    logic        auto_pending;

    logic        req_phase;
    logic        wait_phase;
    logic        rd_address;
    logic        txn_accept;
    logic        txn_complete;
    logic        txn_expired;
    logic [31:0] txn_data;

    logic        id_ok;
    logic        ts_ok;
    logic        can_retry;

    logic        launch;
    logic        cap_id;
    logic        cap_ts;
    logic        do_check;
    logic        do_retry;
    logic        enter_done;
    logic        set_pass;
    logic        set_timeout;

    assign req_phase  = (state == ST_RD_ID_REQ)  || (state == ST_RD_TS_REQ);
    assign wait_phase = (state == ST_RD_ID_WAIT) || (state == ST_RD_TS_WAIT);
    assign rd_address = ((state == ST_RD_TS_REQ) || (state == ST_RD_TS_WAIT))
                        ? SYSID_ADDR_TS : SYSID_ADDR_ID;
    assign busy       = (state != ST_IDLE) && (state != ST_DONE);

    assign id_ok     = (id_value == EXPECTED_ID);
    assign ts_ok     = (ts_value == EXPECTED_TS);
    assign can_retry = (retry_cnt < RETRY_W'(MAX_RETRIES));

    avm_read_txn #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_txn (
        .clock      (clock),
        .reset_n    (reset_n),
        .req_phase  (req_phase),
        .wait_phase (wait_phase),
        .address    (rd_address),
        .avm        (avm),
        .accept     (txn_accept),
        .complete   (txn_complete),
        .expired    (txn_expired),
        .data       (txn_data)
    );

    always_comb begin
        state_nxt   = state;
        launch      = 1'b0;
        cap_id      = 1'b0;
        cap_ts      = 1'b0;
        do_check    = 1'b0;
        do_retry    = 1'b0;
        enter_done  = 1'b0;
        set_pass    = 1'b0;
        set_timeout = 1'b0;

        case (state)
            ST_IDLE: begin
                if (start || auto_pending) begin
                    launch    = 1'b1;
                    state_nxt = ST_RD_ID_REQ;
                end
            end
            ST_DONE: begin
                if (start) begin
                    launch    = 1'b1;
                    state_nxt = ST_RD_ID_REQ;
                end
            end
            ST_RD_ID_REQ, ST_RD_ID_WAIT: begin
                if (txn_complete) begin
                    cap_id    = 1'b1;
                    state_nxt = ST_RD_TS_REQ;
                end else if (txn_expired) begin
                    set_timeout = 1'b1;
                    enter_done  = 1'b1;
                    state_nxt   = ST_DONE;
                end else if ((state == ST_RD_ID_REQ) && txn_accept) begin
                    state_nxt = ST_RD_ID_WAIT;
                end
            end
            ST_RD_TS_REQ, ST_RD_TS_WAIT: begin
                if (txn_complete) begin
                    cap_ts    = 1'b1;
                    state_nxt = ST_CHECK;
                end else if (txn_expired) begin
                    set_timeout = 1'b1;
                    enter_done  = 1'b1;
                    state_nxt   = ST_DONE;
                end else if ((state == ST_RD_TS_REQ) && txn_accept) begin
                    state_nxt = ST_RD_TS_WAIT;
                end
            end
            ST_CHECK: begin
                do_check = 1'b1;
                if (id_ok && ts_ok) begin
                    set_pass   = 1'b1;
                    enter_done = 1'b1;
                    state_nxt  = ST_DONE;
                end else if (can_retry) begin
                    do_retry  = 1'b1;
                    state_nxt = ST_RD_ID_REQ;
                end else begin
                    enter_done = 1'b1;
                    state_nxt  = ST_DONE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state        <= ST_IDLE;
            auto_pending <= AUTO_START;
            done         <= 1'b0;
            pass         <= 1'b0;
            id_match     <= 1'b0;
            ts_match     <= 1'b0;
            timeout      <= 1'b0;
            retry_cnt    <= '0;
            id_value     <= '0;
            ts_value     <= '0;
        end else begin
            state <= state_nxt;
            if (launch) begin
                auto_pending <= 1'b0;
                done         <= 1'b0;
                pass         <= 1'b0;
                id_match     <= 1'b0;
                ts_match     <= 1'b0;
                timeout      <= 1'b0;
                retry_cnt    <= '0;
            end
            if (cap_id) begin
                id_value <= txn_data;
            end
            if (cap_ts) begin
                ts_value <= txn_data;
            end
            if (do_check) begin
                id_match <= id_ok;
                ts_match <= ts_ok;
            end
            if (do_retry) begin
                retry_cnt <= retry_cnt + 1'b1;
            end
            if (enter_done) begin
                done <= 1'b1;
            end
            if (set_pass) begin
                pass <= 1'b1;
            end
            if (set_timeout) begin
                timeout <= 1'b1;
            end
        end
    end

endmodule
